// File: rtl/imul_iterative_rtl.sv
// ---------------------------------------------------------------------------
// imul_iterative_rtl
//
// Iterative shift-add integer multiplier for the TinyRV1 `mul` instruction.
// Returns the low p_nbits bits of a*b. Each operation has a fixed latency,
// because every request runs p_nbits CALC iterations with no early exit.
//
// Parameters
//   p_nbits      operand and result width (power of two, >= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   istream_val  operand request valid
//   istream_rdy  unit can accept a request (IDLE and not in reset)
//   istream_a    multiplicand, sampled only on the accepting edge
//   istream_b    multiplier, sampled only on the accepting edge
//   ostream_val  product valid (DONE state)
//   ostream_rdy  consumer accepts the product
//   ostream_msg  product (a*b) mod 2^p_nbits, driven from result_reg
// ---------------------------------------------------------------------------
module imul_iterative_rtl #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [p_nbits-1:0] istream_a,
    input  logic [p_nbits-1:0] istream_b,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [p_nbits-1:0] ostream_msg
);

    localparam int CW = $clog2(p_nbits) + 1;

    // Value of count during the final CALC iteration.
    localparam logic [CW-1:0] LAST_ITER = CW'(p_nbits - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [p_nbits-1:0] a_reg;
    logic [p_nbits-1:0] b_reg;
    logic [p_nbits-1:0] result_reg;
    logic [CW-1:0]      count;

    logic [p_nbits-1:0] a_next;
    logic [p_nbits-1:0] b_next;
    logic [p_nbits-1:0] result_next;
    logic [CW-1:0]      count_next;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set. The sum wraps, which is exactly the low half
    // of the product for both signed and unsigned operands.
    function automatic logic [p_nbits-1:0] add_partial(
        input logic [p_nbits-1:0] acc,
        input logic [p_nbits-1:0] mcand,
        input logic               bit0
    );
        add_partial = bit0 ? (acc + mcand) : acc;
    endfunction

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            count      <= '0;
        end else begin
            state      <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            result_reg <= result_next;
            count      <= count_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result_reg;
        count_next  = count;

        unique case (state)
            IDLE: begin
                if (istream_val && istream_rdy) begin
                    a_next      = istream_a;
                    b_next      = istream_b;
                    result_next = '0;
                    count_next  = '0;
                    state_next  = CALC;
                end
            end

            CALC: begin
                result_next = add_partial(result_reg, a_reg, b_reg[0]);
                a_next      = a_reg << 1;
                b_next      = b_reg >> 1;
                count_next  = count + 1'b1;
                if (count == LAST_ITER) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                if (ostream_rdy) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: registered state only, plus rst forcing istream_rdy low so a
    // request cannot be presented as accepted while the unit is held in reset.
    // -----------------------------------------------------------------------
    assign istream_rdy = (state == IDLE) && !rst;
    assign ostream_val = (state == DONE);
    assign ostream_msg = result_reg;

endmodule

// File: tb/tb_imul_iterative_rtl.sv
module tb_imul_iterative_rtl;

    logic        clk;
    logic        rst;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] istream_a;
    logic [31:0] istream_b;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] ostream_msg;

    int checks;
    int failures;

    imul_iterative_rtl #(.p_nbits(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_a   (istream_a),
        .istream_b   (istream_b),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: low 32 bits of the full 64-bit product.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request with ostream_rdy high; returns the product and the
    // number of cycles from the first CALC cycle to the ostream_val cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        int w;
        istream_val = 1'b1;
        istream_a   = a;
        istream_b   = b;
        w = 0;
        while (!istream_rdy && w < 100) begin
            step();
            w++;
        end
        step();
        istream_val = 1'b0;
        istream_a   = $urandom;
        istream_b   = $urandom;
        lat = 1;
        while (!ostream_val && lat < 100) begin
            step();
            lat++;
        end
        res = ostream_msg;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] first_res;
        logic [31:0] second_res;
        int          lat;
        int          w;
        int          got_first;
        int          got_second;
        logic [31:0] exp_q[$];
        int          sent;
        int          recv;
        int          cyc;
        logic        in_hs;
        logic        out_hs;

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        istream_val = 1'b0;
        istream_a   = '0;
        istream_b   = '0;
        ostream_rdy = 1'b1;

        // Reset state before any clock edge
        #1;
        check("reset_istream_rdy", {31'd0, istream_rdy}, 32'd0);
        check("reset_ostream_val", {31'd0, ostream_val}, 32'd0);
        check("reset_ostream_msg", ostream_msg, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_reset_istream_rdy", {31'd0, istream_rdy}, 32'd1);

        // 3 x 7 with full timing
        istream_val = 1'b1;
        istream_a   = 32'd3;
        istream_b   = 32'd7;
        step();
        istream_val = 1'b0;
        check("3x7_rdy_drop", {31'd0, istream_rdy}, 32'd0);
        lat = 1;
        while (!ostream_val && lat < 100) begin
            step();
            lat++;
        end
        check("3x7_latency", lat, 32'd33);
        check("3x7_msg", ostream_msg, 32'd21);
        step();
        check("3x7_val_one_cycle", {31'd0, ostream_val}, 32'd0);
        check("3x7_rdy_back", {31'd0, istream_rdy}, 32'd1);

        // Boundaries
        do_op(32'd0, 32'hFFFFFFFF, res, lat);
        check("zero_x_ones", res, 32'd0);
        step();
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
        check("ones_x_ones", res, 32'h00000001);
        check("ones_x_ones_latency", lat, 32'd33);
        step();
        do_op(32'h80000000, 32'd2, res, lat);
        check("msb_x_two", res, 32'd0);
        step();
        do_op(32'hFFFFFFFB, 32'd6, res, lat);
        check("neg5_x_6", res, 32'hFFFFFFE2);
        step();

        // Back-pressure on 12 x 12
        ostream_rdy = 1'b0;
        do_op(32'd12, 32'd12, res, lat);
        check("bp_first_msg", res, 32'd144);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_val", {31'd0, ostream_val}, 32'd1);
            check("bp_hold_msg", ostream_msg, 32'd144);
            check("bp_hold_in_rdy", {31'd0, istream_rdy}, 32'd0);
            step();
        end
        ostream_rdy = 1'b1;
        step();
        check("bp_consumed_val", {31'd0, ostream_val}, 32'd0);
        check("bp_consumed_rdy", {31'd0, istream_rdy}, 32'd1);

        // Busy-drop: 5 x 5 then a held request with churning operands
        istream_val = 1'b1;
        istream_a   = 32'd5;
        istream_b   = 32'd5;
        step();
        got_first  = 0;
        got_second = 0;
        first_res  = '0;
        second_res = '0;
        w = 0;
        while (!istream_rdy && w < 100) begin
            if (ostream_val) begin
                got_first = 1;
                first_res = ostream_msg;
            end
            istream_a = $urandom;
            istream_b = $urandom;
            step();
            w++;
        end
        istream_a = 32'd9;
        istream_b = 32'd9;
        step();
        istream_val = 1'b0;
        istream_a   = 32'hDEADBEEF;
        istream_b   = 32'hCAFEF00D;
        w = 0;
        while (!ostream_val && w < 100) begin
            step();
            w++;
        end
        second_res = ostream_msg;
        got_second = ostream_val ? 1 : 0;
        check("busy_first_seen", got_first, 32'd1);
        check("busy_first_msg", first_res, 32'd25);
        check("busy_second_seen", got_second, 32'd1);
        check("busy_second_msg", second_res, 32'd81);
        step();

        // Async reset 10 cycles into CALC
        istream_val = 1'b1;
        istream_a   = 32'd1234;
        istream_b   = 32'd5678;
        step();
        istream_val = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #3;
        rst = 1'b1;
        #1;
        check("arst_ostream_val", {31'd0, ostream_val}, 32'd0);
        check("arst_istream_rdy", {31'd0, istream_rdy}, 32'd0);
        check("arst_ostream_msg", ostream_msg, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("arst_release_rdy", {31'd0, istream_rdy}, 32'd1);
        check("arst_release_val", {31'd0, ostream_val}, 32'd0);
        do_op(32'd2, 32'd3, res, lat);
        check("arst_after_latency", lat, 32'd33);
        check("arst_after_msg", res, 32'd6);
        step();

        // Random regression with random gaps on both streams
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 1000 && cyc < 90000) begin
            ostream_rdy = ($urandom_range(3) != 0);
            if (!istream_val && sent < 1000 && $urandom_range(2) == 0) begin
                istream_val = 1'b1;
                istream_a   = $urandom;
                istream_b   = $urandom;
            end
            in_hs  = istream_val && istream_rdy;
            out_hs = ostream_val && ostream_rdy;
            if (in_hs) begin
                exp_q.push_back(ref_mul(istream_a, istream_b));
                sent++;
            end
            if (out_hs) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_output", ostream_msg, 32'hFFFFFFFF ^ ostream_msg);
                end else begin
                    check("rand_product", ostream_msg, exp_q.pop_front());
                end
                recv++;
            end
            step();
            cyc++;
            if (in_hs) istream_val = 1'b0;
        end
        check("rand_received", recv, 32'd1000);
        check("rand_sent", sent, 32'd1000);
        check("rand_queue_empty", exp_q.size(), 32'd0);
        ostream_rdy = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check("rand_no_duplicate", {31'd0, ostream_val}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
